lcd_mode_ctrl: RTL and testbench

LCD_MODE_CTRL -- requirements
Module: lcd_mode_ctrl

---
 rtl/lcd_pkg.sv | 36 +++
 rtl/key_press_det.sv | 80 ++++++++
 rtl/lcd_mode_ctrl.sv | 63 ++++++
 tb/tb_lcd_mode_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants for the LCD mode controller: display mode codes,
// mode width and the key FSM state encoding.
package lcd_pkg;

  localparam int MODE_W = 4;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_BLACK    = 4'd0;
  localparam mode_t MODE_WHITE    = 4'd1;
  localparam mode_t MODE_RED      = 4'd2;
  localparam mode_t MODE_GREEN    = 4'd3;
  localparam mode_t MODE_BLUE     = 4'd4;
  localparam mode_t MODE_YELLOW   = 4'd5;
  localparam mode_t MODE_CYAN     = 4'd6;
  localparam mode_t MODE_MAGENTA  = 4'd7;
  localparam mode_t MODE_GRAY_H   = 4'd8;
  localparam mode_t MODE_GRAY_V   = 4'd9;
  localparam mode_t MODE_GRID     = 4'd10;
  localparam mode_t MODE_CHECKER  = 4'd11;
  localparam mode_t MODE_COLORBAR = 4'd12;

  typedef enum logic [1:0] {
    KEY_IDLE = 2'd0,
    KEY_DEB  = 2'd1,
    KEY_HELD = 2'd2,
    KEY_LONG = 2'd3
  } key_state_t;

  // Wraps to black past the last mode; also recovers from any
  // out-of-range code so nothing above the top is ever produced.
  function automatic mode_t next_mode(mode_t m, mode_t top);
    return (m >= top) ? MODE_BLACK : mode_t'(m + 1'b1);
  endfunction

endpackage

// File: rtl/key_press_det.sv
// Push-button synchronizer, debouncer and short/long press detector.
// Pulses are one cycle wide and combinational from the FSM state.
module key_press_det
  import lcd_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 90000,
  parameter int LONG_CYC     = 9000000
) (
  input  logic clk,
  input  logic reset,
  input  logic key1,
  output logic short_press,
  output logic long_press
);

  localparam logic [23:0] DEB_LAST  = 24'(DEBOUNCE_CYC - 1);
  localparam logic [23:0] LONG_LAST = 24'(LONG_CYC - 1);

  logic        key_m;
  logic        key_s;
  key_state_t  state;
  key_state_t  state_n;
  logic [23:0] cnt;
  logic [23:0] cnt_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_m <= 1'b1;
      key_s <= 1'b1;
      state <= KEY_IDLE;
      cnt   <= '0;
    end else begin
      key_m <= key1;
      key_s <= key_m;
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    short_press = 1'b0;
    long_press  = 1'b0;
    unique case (state)
      KEY_IDLE: begin
        if (!key_s) begin
          state_n = KEY_DEB;
          cnt_n   = '0;
        end
      end
      KEY_DEB: begin
        if (key_s) begin
          state_n = KEY_IDLE;
        end else if (cnt == DEB_LAST) begin
          state_n = KEY_HELD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 24'd1;
        end
      end
      KEY_HELD: begin
        if (key_s) begin
          state_n     = KEY_IDLE;
          short_press = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_n    = KEY_LONG;
          long_press = 1'b1;
        end else begin
          cnt_n = cnt + 24'd1;
        end
      end
      KEY_LONG: begin
        if (key_s) state_n = KEY_IDLE;
      end
      default: state_n = KEY_IDLE;
    endcase
  end

endmodule

// File: rtl/lcd_mode_ctrl.sv
// Display mode selector: manual stepping on short press, auto-cycle
// toggled by long press, all mode changes aligned to frame_start.
module lcd_mode_ctrl
  import lcd_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 90000,
  parameter int LONG_CYC     = 9000000,
  parameter int DWELL_FRAMES = 120,
  parameter int MODE_MAX     = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key1,
  input  logic              frame_start,
  output logic [MODE_W-1:0] dis_mode,
  output logic              mode_upd,
  output logic              auto_en
);

  localparam logic [7:0] DWELL_LAST = 8'(DWELL_FRAMES - 1);
  localparam mode_t      MODE_LAST  = mode_t'(MODE_MAX);

  logic       short_press;
  logic       long_press;
  logic       pending;
  logic [7:0] fcnt;
  logic       step;
  logic       dwell_hit;

  key_press_det #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .LONG_CYC     (LONG_CYC)
  ) u_key (
    .clk         (clk),
    .reset       (reset),
    .key1        (key1),
    .short_press (short_press),
    .long_press  (long_press)
  );

  assign step      = frame_start & pending;
  assign dwell_hit = frame_start & auto_en & (fcnt == DWELL_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= 1'b0;
      fcnt     <= '0;
      dis_mode <= MODE_BLACK;
      mode_upd <= 1'b0;
      auto_en  <= 1'b0;
    end else begin
      mode_upd <= step;
      if (step) dis_mode <= next_mode(dis_mode, MODE_LAST);
      if (long_press) auto_en <= ~auto_en;
      // A step consumes pending even if a press lands in the same cycle.
      if (step) pending <= 1'b0;
      else if (short_press | dwell_hit) pending <= 1'b1;
      if (long_press | step | dwell_hit) fcnt <= '0;
      else if (frame_start & auto_en) fcnt <= fcnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_lcd_mode_ctrl.sv
// Directed bench for lcd_mode_ctrl with short debounce/long/dwell
// settings and a frame_start pulse every 50 cycles.
module tb_lcd_mode_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key1 = 1'b1;
  logic       frame_start = 1'b0;
  logic [3:0] dis_mode;
  logic       mode_upd;
  logic       auto_en;

  int total = 0;
  int passed = 0;
  int cyc = 0;

  lcd_mode_ctrl #(
    .DEBOUNCE_CYC (4),
    .LONG_CYC     (20),
    .DWELL_FRAMES (3),
    .MODE_MAX     (12)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key1        (key1),
    .frame_start (frame_start),
    .dis_mode    (dis_mode),
    .mode_upd    (mode_upd),
    .auto_en     (auto_en)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    frame_start = (cyc % 50 == 0);
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Run until the next frame_start has been sampled by the DUT.
  task automatic to_frame_edge();
    for (int i = 0; i < 60 && !frame_start; i++) tick();
    total++;
    assert (frame_start) passed++;
    else $error("FAIL frame_timeout: got %0d expected %0d", frame_start, 1);
    tick();
  endtask

  task automatic press(input int n);
    key1 = 1'b0;
    repeat (n) tick();
    key1 = 1'b1;
    repeat (6) tick();
  endtask

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    check("rst_mode", dis_mode, 0);
    check("rst_upd", mode_upd, 0);
    check("rst_auto", auto_en, 0);

    press(3);
    to_frame_edge();
    check("glitch_mode1", dis_mode, 0);
    check("glitch_upd", mode_upd, 0);
    to_frame_edge();
    check("glitch_mode2", dis_mode, 0);

    press(10);
    to_frame_edge();
    check("short_mode", dis_mode, 1);
    check("short_upd_hi", mode_upd, 1);
    tick();
    check("short_upd_lo", mode_upd, 0);
    to_frame_edge();
    check("short_hold", dis_mode, 1);

    press(10);
    press(10);
    press(10);
    to_frame_edge();
    check("triple_mode", dis_mode, 2);
    to_frame_edge();
    check("triple_hold", dis_mode, 2);

    for (int i = 3; i <= 12; i++) begin
      press(10);
      to_frame_edge();
      check("walk_mode", dis_mode, i);
    end
    press(10);
    to_frame_edge();
    check("wrap_mode", dis_mode, 0);
    check("wrap_upd", mode_upd, 1);

    press(30);
    check("long_auto_on", auto_en, 1);
    check("long_no_step", dis_mode, 0);
    repeat (3) to_frame_edge();
    check("dwell_wait", dis_mode, 0);
    to_frame_edge();
    check("dwell_step1", dis_mode, 1);
    check("dwell_upd", mode_upd, 1);
    repeat (3) to_frame_edge();
    check("dwell_wait2", dis_mode, 1);
    to_frame_edge();
    check("dwell_step2", dis_mode, 2);
    press(30);
    check("long_auto_off", auto_en, 0);
    repeat (5) to_frame_edge();
    check("auto_off_hold", dis_mode, 2);

    press(10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstA_mode", dis_mode, 0);
    to_frame_edge();
    check("rstA_pend_lost", dis_mode, 0);

    press(10);
    key1 = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstB_mode", dis_mode, 0);
    check("rstB_upd", mode_upd, 0);
    check("rstB_auto", auto_en, 0);
    repeat (12) tick();
    key1 = 1'b1;
    repeat (6) tick();
    to_frame_edge();
    check("rstB_fresh", dis_mode, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
